// File: rtl/diagonal_scheduler.sv
// Anti-diagonal wavefront scheduler for a square PU grid of 2x2-PE units.
// It sequences load, diagonal compute, max-tree wait and traceback, and every output comes from a register.
module diagonal_scheduler #(
  parameter int NUM_PU_MAIN_DIAGONAL = 16,
  parameter int NUM_DIAGONALS        = 31,
  parameter int NUM_PE_IN_PU         = 4
) (
  input  logic                                    clk,
  input  logic                                    rst,
  input  logic                                    start,
  input  logic                                    buf_ready,
  input  logic                                    stall,
  input  logic                                    max_done,
  input  logic                                    tb_done,
  output logic                                    busy,
  output logic [$clog2(NUM_DIAGONALS)-1:0]        diag_idx,
  output logic [1:0]                              pe_phase,
  output logic [NUM_PU_MAIN_DIAGONAL-1:0]         pu_en,
  output logic [NUM_PE_IN_PU-1:0]                 pe_mask,
  output logic [$clog2(NUM_PU_MAIN_DIAGONAL)-1:0] row_base,
  output logic [$clog2(NUM_PU_MAIN_DIAGONAL)-1:0] col_base,
  output logic                                    max_start,
  output logic                                    tb_start,
  output logic                                    done
);

  localparam int DW = $clog2(NUM_DIAGONALS);
  localparam int RW = $clog2(NUM_PU_MAIN_DIAGONAL);
  localparam int CW = $clog2(NUM_PU_MAIN_DIAGONAL + 1);
  localparam logic [DW-1:0] LAST_DIAG  = DW'(NUM_DIAGONALS - 1);
  localparam logic [DW-1:0] MAIN_DIAG  = DW'(NUM_PU_MAIN_DIAGONAL - 1);
  localparam logic [1:0]    LAST_PHASE = 2'd2;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    COMPUTE,
    MAX_WAIT,
    TRACEBACK,
    DONE
  } state_t;

  state_t                   state_reg, state_next;
  logic [DW-1:0]            diag_reg, diag_next;
  logic [1:0]               phase_reg, phase_next;
  logic                     fire;
  logic [CW-1:0]            active_cnt;
  logic [RW-1:0]            row_next, col_next;
  logic [NUM_PU_MAIN_DIAGONAL-1:0] pu_en_reg, pu_en_next;
  logic [NUM_PE_IN_PU-1:0]  pe_mask_reg, pe_mask_next;
  logic [RW-1:0]            row_reg, col_reg;
  logic                     busy_reg, max_start_reg, tb_start_reg, done_reg;

  // fire marks that the coming cycle issues a real wavefront step; a stalled
  // COMPUTE cycle keeps the step position but issues nothing.
  always_comb begin
    state_next = state_reg;
    diag_next  = diag_reg;
    phase_next = phase_reg;
    fire       = 1'b0;
    case (state_reg)
      IDLE: begin
        if (start) state_next = LOAD;
      end
      LOAD: begin
        if (buf_ready) begin
          state_next = COMPUTE;
          diag_next  = '0;
          phase_next = '0;
          fire       = 1'b1;
        end
      end
      COMPUTE: begin
        if (!stall) begin
          if (diag_reg == LAST_DIAG && phase_reg == LAST_PHASE) begin
            state_next = MAX_WAIT;
            diag_next  = '0;
            phase_next = '0;
          end else if (phase_reg == LAST_PHASE) begin
            diag_next  = diag_reg + DW'(1);
            phase_next = '0;
            fire       = 1'b1;
          end else begin
            phase_next = phase_reg + 2'd1;
            fire       = 1'b1;
          end
        end
      end
      MAX_WAIT: begin
        if (max_done) state_next = TRACEBACK;
      end
      TRACEBACK: begin
        if (tb_done) state_next = DONE;
      end
      DONE: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // Diagonal geometry: grows along the top row, then shrinks down the last column.
  always_comb begin
    if (diag_next <= MAIN_DIAG) begin
      active_cnt = CW'(diag_next) + CW'(1);
      row_next   = '0;
      col_next   = RW'(diag_next);
    end else begin
      active_cnt = CW'(DW'(NUM_DIAGONALS) - diag_next);
      row_next   = RW'(diag_next - MAIN_DIAG);
      col_next   = RW'(MAIN_DIAG);
    end
  end

  generate
    for (genvar gi = 0; gi < NUM_PU_MAIN_DIAGONAL; gi++) begin : g_pu_en
      assign pu_en_next[gi] = fire && (active_cnt > CW'(gi));
    end
    // Inside a 2x2 PU a PE fires on the step equal to its row plus column.
    for (genvar gi = 0; gi < NUM_PE_IN_PU; gi++) begin : g_pe_mask
      localparam logic [1:0] PE_STEP = 2'((gi / 2) + (gi % 2));
      assign pe_mask_next[gi] = fire && (phase_next == PE_STEP);
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg     <= IDLE;
      diag_reg      <= '0;
      phase_reg     <= '0;
      pu_en_reg     <= '0;
      pe_mask_reg   <= '0;
      row_reg       <= '0;
      col_reg       <= '0;
      busy_reg      <= 1'b0;
      max_start_reg <= 1'b0;
      tb_start_reg  <= 1'b0;
      done_reg      <= 1'b0;
    end else begin
      state_reg     <= state_next;
      diag_reg      <= diag_next;
      phase_reg     <= phase_next;
      pu_en_reg     <= pu_en_next;
      pe_mask_reg   <= pe_mask_next;
      if (fire) begin
        row_reg <= row_next;
        col_reg <= col_next;
      end
      busy_reg      <= (state_next != IDLE);
      max_start_reg <= (state_next == MAX_WAIT) && (state_reg != MAX_WAIT);
      tb_start_reg  <= (state_next == TRACEBACK) && (state_reg != TRACEBACK);
      done_reg      <= (state_next == DONE);
    end
  end

  assign busy      = busy_reg;
  assign diag_idx  = diag_reg;
  assign pe_phase  = phase_reg;
  assign pu_en     = pu_en_reg;
  assign pe_mask   = pe_mask_reg;
  assign row_base  = row_reg;
  assign col_base  = col_reg;
  assign max_start = max_start_reg;
  assign tb_start  = tb_start_reg;
  assign done      = done_reg;

endmodule
